pipeline_if_stage: RTL and testbench
====================================

// Module: pipeline_if_stage
// PURPOSE
//  Instruction-fetch stage with PC register and IF/ID pipeline register, directly upstream of the ID-stage control unit.
//  Fetches over a req/ready instruction-memory handshake; one-entry hold buffer.
//  Acts on ID's load-use stall and resolved jump/branch redirect; no delay slot, so the word fetched behind a redirect is squashed.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0000  bubble word written into IF/ID on flush/empty
// PORTS
//  clk                 in   1   single clock, rising edge
//  rst                 in   1   synchronous, active-high reset
//  shouldStall         in   1   from ID ctrl: hold PC and IF/ID this cycle
//  shouldJumpOrBranch  in   1   from ID ctrl: redirect fetch this cycle
//  redirectTarget      in   32  jump/branch/jr target computed in ID
//  imem_req            out  1   fetch request
//  imem_addr           out  32  fetch address, stable while request outstanding
//  imem_rdata          in   32  instruction word, valid when imem_ready=1
//  imem_ready          in   1   word returned this cycle (may be same cycle as req)
//  id_instruction      out  32  IF/ID: instruction to ID
//  id_pc               out  32  IF/ID: address of id_instruction
//  id_pcPlus4          out  32  IF/ID: id_pc+4 (jal link / branch base)
//  id_valid            out  1   IF/ID holds a real instruction (0 = bubble)
//  perf_stallCycles    out  32  see CONFIGURATION
//  perf_flushCount     out  32  see CONFIGURATION
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=RUN, id_instruction=NOP_INSTR, id_pc=id_pcPlus4=0, id_valid=0, counters=0; imem_req=0 while rst=1.
//  States (2-bit): RUN, WAIT (req outstanding), DISCARD (drop stale return), BUFFERED (word held by stall).
//  Registers: pc, req_addr (latched on req issue), buf_instr, state, IF/ID.
//  imem_addr = (state==RUN) ? pc : req_addr.
//  imem_req  = !rst && (state==WAIT || state==DISCARD || (state==RUN && !shouldStall)).
//  Priority per edge: rst > shouldJumpOrBranch > shouldStall > normal advance.
//  Redirect: pc<=redirectTarget & ~32'h3; IF/ID<=bubble; +1 flushCount; redirect with stall=1 is still a redirect.
//  RUN:
//   - redirect: as above; if req issued and !imem_ready -> DISCARD, else stay RUN.
//   - stall: pc, IF/ID hold; no request issued.
//   - ready: IF/ID<={imem_rdata,pc,pc+4,1}; pc<=pc+4.
//   - !ready: IF/ID<=bubble; req_addr<=pc; ->WAIT.
//  WAIT:
//   - redirect & ready: word dropped; ->RUN.
//   - redirect & !ready: ->DISCARD.
//   - ready & stall: buf_instr<=imem_rdata; IF/ID hold; ->BUFFERED.
//   - ready & !stall: IF/ID<={imem_rdata,req_addr,req_addr+4,1}; pc<=req_addr+4; ->RUN.
//   - !ready & !stall: IF/ID<=bubble; stay WAIT.
//   - !ready & stall: IF/ID hold; stay WAIT.
//  DISCARD: pc already holds target; IF/ID<=bubble unless stall; on ready drop word ->RUN; a further redirect updates pc, stays DISCARD.
//  BUFFERED: no req. !stall: IF/ID<={buf_instr,pc,pc+4,1}; pc<=pc+4; ->RUN. Redirect drops buffer, ->RUN.
//  Arithmetic: pc+4 mod 2^32, 0xFFFF_FFFC wraps to 0; no misalignment exception.
//  Stall never loses or duplicates an instruction; each fetched word enters IF/ID at most once.
// CONFIGURATION
//  IF_PERF_CNT_EN defined:
//   - perf_stallCycles +1 each cycle shouldStall=1 and no redirect.
//   - perf_flushCount +1 each redirect.
//   - Both 32-bit wrapping, cleared by rst.
//  Undefined: both outputs tied to 32'h0, no counter flops synthesized.
// TESTING
//  1 rst, imem_ready=1 constant, no stall: id_pc 0,4,8,... one per cycle; id_valid=1 from 2nd edge after rst falls.
//  2 stall 2 cycles with id_pc=8: id_instruction/id_pc hold at 8, pc holds 12, imem_req=0; resumes 12; stallCycles=2 with EN.
//  3 redirect to 0x40 while id_pc=0x10: next IF/ID bubble (id_valid=0), then id_pc=0x40; addr 0x14 never reaches ID; flushCount=1.
//  4 imem_ready low 3 cycles at pc=0x20: imem_addr stable 0x20, 3 bubbles, then id_pc=0x20.
//  5 redirect to 0x80 in WAIT with ready low 2 more cycles: stale word dropped; next valid id_pc=0x80, address 0x80 fetched after the stale return.
//  6 ready arrives with stall=1 in WAIT: word buffered; stall drops; id_instruction equals buffered word, id_pc correct, no duplicate.

Source files
------------

// File: rtl/pipeline_if_stage.sv
// Instruction fetch: PC register, imem req/ready handshake, one-entry hold buffer, IF/ID register.
// Latency: a word returned on imem_ready reaches IF/ID at the next edge (from the buffer once a stall clears).
// Backpressure: shouldStall holds PC and IF/ID. Perf counters are present only when IF_PERF_CNT_EN is defined.
module pipeline_if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shouldStall,
    input  logic        shouldJumpOrBranch,
    input  logic [31:0] redirectTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcPlus4,
    output logic        id_valid,
    output logic [31:0] perf_stallCycles,
    output logic [31:0] perf_flushCount
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic        valid;
    } ifIdT;

    localparam ifIdT BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pcPlus4: 32'h0, valid: 1'b0};

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] WAIT     = 2'd1;
    localparam logic [1:0] DISCARD  = 2'd2;
    localparam logic [1:0] BUFFERED = 2'd3;

    logic [1:0]  state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] reqAddr, reqAddrNext;
    logic [31:0] bufInstr, bufInstrNext;
    ifIdT        ifId, ifIdNext;
    logic [31:0] redirectPc;

    assign redirectPc = redirectTarget & ~32'h3;

    // The address stays on reqAddr for every cycle a request is outstanding.
    assign imem_addr = (state == RUN) ? pc : reqAddr;
    assign imem_req  = !rst && ((state == WAIT) || (state == DISCARD) ||
                                ((state == RUN) && !shouldStall));

    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        reqAddrNext  = reqAddr;
        bufInstrNext = bufInstr;
        ifIdNext     = ifId;
        if (shouldJumpOrBranch) begin
            // No delay slot: whatever was in flight behind the redirect is squashed.
            pcNext   = redirectPc;
            ifIdNext = BUBBLE;
            case (state)
                RUN: begin
                    if (imem_req && !imem_ready) begin
                        reqAddrNext = pc;
                        stateNext   = DISCARD;
                    end
                end
                WAIT, DISCARD: stateNext = imem_ready ? RUN : DISCARD;
                default:       stateNext = RUN;
            endcase
        end else begin
            case (state)
                RUN: begin
                    if (!shouldStall) begin
                        if (imem_ready) begin
                            ifIdNext = '{instr: imem_rdata, pc: pc, pcPlus4: pc + 32'd4, valid: 1'b1};
                            pcNext   = pc + 32'd4;
                        end else begin
                            ifIdNext    = BUBBLE;
                            reqAddrNext = pc;
                            stateNext   = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (imem_ready) begin
                        if (shouldStall) begin
                            bufInstrNext = imem_rdata;
                            stateNext    = BUFFERED;
                        end else begin
                            ifIdNext  = '{instr: imem_rdata, pc: reqAddr,
                                          pcPlus4: reqAddr + 32'd4, valid: 1'b1};
                            pcNext    = reqAddr + 32'd4;
                            stateNext = RUN;
                        end
                    end else if (!shouldStall) begin
                        ifIdNext = BUBBLE;
                    end
                end
                DISCARD: begin
                    if (!shouldStall) ifIdNext = BUBBLE;
                    if (imem_ready) stateNext = RUN;
                end
                default: begin
                    if (!shouldStall) begin
                        ifIdNext  = '{instr: bufInstr, pc: pc, pcPlus4: pc + 32'd4, valid: 1'b1};
                        pcNext    = pc + 32'd4;
                        stateNext = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            reqAddr  <= RESET_PC;
            bufInstr <= NOP_INSTR;
            ifId     <= BUBBLE;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            reqAddr  <= reqAddrNext;
            bufInstr <= bufInstrNext;
            ifId     <= ifIdNext;
        end
    end

    assign id_instruction = ifId.instr;
    assign id_pc          = ifId.pc;
    assign id_pcPlus4     = ifId.pcPlus4;
    assign id_valid       = ifId.valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= 32'h0;
            flushCnt <= 32'h0;
        end else begin
            if (shouldJumpOrBranch) flushCnt <= flushCnt + 32'd1;
            else if (shouldStall)   stallCnt <= stallCnt + 32'd1;
        end
    end

    assign perf_stallCycles = stallCnt;
    assign perf_flushCount  = flushCnt;
`else
    assign perf_stallCycles = 32'h0;
    assign perf_flushCount  = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Bench for pipeline_if_stage: directed scenarios then random stall/redirect/ready traffic against a transaction model.
module tb_pipeline_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        shouldStall;
    logic        shouldJumpOrBranch;
    logic [31:0] redirectTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pcPlus4;
    logic        id_valid;
    logic [31:0] perf_stallCycles;
    logic [31:0] perf_flushCount;

    int checks = 0;
    int errors = 0;

    pipeline_if_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .shouldStall(shouldStall), .shouldJumpOrBranch(shouldJumpOrBranch),
        .redirectTarget(redirectTarget),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .id_instruction(id_instruction), .id_pc(id_pc), .id_pcPlus4(id_pcPlus4),
        .id_valid(id_valid),
        .perf_stallCycles(perf_stallCycles), .perf_flushCount(perf_flushCount)
    );

    always #5 clk = ~clk;

    // Model: next address to fetch, one outstanding request (possibly stale), one held word, expected IF/ID.
    logic [31:0] mPc, mOutAddr, mHeldWord;
    bit          mOut, mStale, mHeld;
    logic [31:0] eInstr, ePc, ePc4;
    bit          eValid;
    logic [31:0] eStalls, eFlushes;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPc = 32'h0; mOut = 0; mStale = 0; mHeld = 0; mOutAddr = 0; mHeldWord = 0;
        eInstr = NOP; ePc = 0; ePc4 = 0; eValid = 0; eStalls = 0; eFlushes = 0;
    endtask

    task automatic bubble();
        eInstr = NOP; ePc = 0; ePc4 = 0; eValid = 0;
    endtask

    task automatic deliver(input logic [31:0] w, input logic [31:0] a);
        eInstr = w; ePc = a; ePc4 = a + 32'd4; eValid = 1;
    endtask

    task automatic checkIfId();
        chk("id_valid", {31'h0, id_valid}, {31'h0, eValid});
        chk("id_instruction", id_instruction, eInstr);
        if (eValid) begin
            chk("id_pc", id_pc, ePc);
            chk("id_pcPlus4", id_pcPlus4, ePc4);
        end
`ifdef IF_PERF_CNT_EN
        chk("perf_stallCycles", perf_stallCycles, eStalls);
        chk("perf_flushCount", perf_flushCount, eFlushes);
`else
        chk("perf_stallCycles", perf_stallCycles, 32'h0);
        chk("perf_flushCount", perf_flushCount, 32'h0);
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1; shouldStall = 0; shouldJumpOrBranch = 0; redirectTarget = 0;
        imem_ready = 0; imem_rdata = 0;
        #1 chk("imem_req_in_reset", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        chk("imem_req_in_reset2", {31'h0, imem_req}, 32'h0);
        rst = 0;
        modelReset();
    endtask

    // One cycle: check registered outputs, drive inputs, check request, advance the model.
    task automatic step(input bit s, input bit r, input logic [31:0] tgt, input int pct);
        bit          expReq, rdy;
        logic [31:0] expAddr;
        @(negedge clk);
        checkIfId();
        shouldStall = s; shouldJumpOrBranch = r; redirectTarget = tgt;
        expReq  = mOut || (!mHeld && !s);
        expAddr = mOut ? mOutAddr : mPc;
        #1;
        chk("imem_req", {31'h0, imem_req}, {31'h0, expReq});
        if (expReq) chk("imem_addr", imem_addr, expAddr);
        rdy = expReq && ($urandom_range(99) < pct);
        imem_ready = rdy;
        imem_rdata = rdy ? memWord(expAddr) : 32'hDEAD_BEEF;
        if (r) begin
            eFlushes++;
            bubble();
            mHeld = 0;
            if (expReq && !rdy) begin
                mOut = 1; mStale = 1; mOutAddr = expAddr;
            end else begin
                mOut = 0; mStale = 0;
            end
            mPc = tgt & ~32'h3;
        end else begin
            if (s) eStalls++;
            if (expReq && rdy) begin
                if (mStale) begin
                    if (!s) bubble();
                end else if (s) begin
                    mHeld = 1; mHeldWord = memWord(expAddr);
                end else begin
                    deliver(memWord(expAddr), expAddr);
                    mPc = expAddr + 32'd4;
                end
                mOut = 0; mStale = 0;
            end else if (expReq) begin
                if (!mStale) begin
                    mOut = 1; mOutAddr = expAddr;
                end
                if (!s) bubble();
            end else if (mHeld && !s) begin
                deliver(mHeldWord, mPc);
                mPc = mPc + 32'd4;
                mHeld = 0;
            end
        end
    endtask

    initial begin
        rst = 1; shouldStall = 0; shouldJumpOrBranch = 0; redirectTarget = 0;
        imem_ready = 0; imem_rdata = 0;
        doReset();

        // Streaming with ready tied high
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 100);
        // Stall two cycles
        step(1, 0, 32'h0, 100);
        step(1, 0, 32'h0, 100);
        for (int i = 0; i < 2; i++) step(0, 0, 32'h0, 100);
        // Redirect to 0x40 (id_pc=0x10 in flight)
        step(0, 1, 32'h40, 100);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 100);
        // Memory not ready for 3 cycles
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 32'h0, 100);
        // Redirect while waiting, stale return afterwards
        step(0, 0, 32'h0, 0);
        step(0, 1, 32'h80, 0);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 100);
        // Return arrives during a stall in WAIT, then stall clears
        step(0, 0, 32'h0, 0);
        step(1, 0, 32'h0, 100);
        step(1, 0, 32'h0, 100);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 100);
        // Redirect + stall together, unaligned target, PC wraparound
        step(1, 1, 32'hFFFF_FFF7, 100);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 100);
        // Redirect from the buffered state
        step(0, 0, 32'h0, 0);
        step(1, 0, 32'h0, 100);
        step(1, 1, 32'h0000_0202, 100);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 100);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(99) < 20, $urandom_range(99) < 8, $urandom,
                 int'($urandom_range(100, 20)));
        doReset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(99) < 35, $urandom_range(99) < 15, $urandom,
                 int'($urandom_range(100, 0)));

        @(negedge clk);
        checkIfId();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
